// File: rtl/self_reload_counter_gen2.sv
// Programmable up/down period counter with auto-reload or one-shot stop and a terminal-count pulse.
// Optional macro WRAP_CNT_EN adds wrap_cnt_o, a saturating count of terminal events.
module self_reload_counter_gen2 #(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned RESET_RELOAD = 0,
    parameter int unsigned WRAP_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             start_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             running_o,
    output logic [WIDTH-1:0] reload_val_o
`ifdef WRAP_CNT_EN
    ,
    output logic [WRAP_W-1:0] wrap_cnt_o
`endif
);

    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_RELOAD);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_next;
    logic [WIDTH-1:0] w_term;
    logic             w_at_term;
    logic             w_tc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_RUN;
            r_count  <= RST_VAL;
            r_reload <= RST_VAL;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_reload <= w_reload_next;
        end
    end

    // Terminal follows the live direction input, so a direction flip re-targets immediately.
    always_comb begin
        w_term        = dir_i ? '0 : '1;
        w_at_term     = (r_count == w_term);
        w_tc          = (r_state == ST_RUN) && en_i && w_at_term;
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_reload_next = r_reload;
        if (load_i) begin
            w_reload_next = load_val_i;
            w_count_next  = load_val_i;
            w_state_next  = ST_RUN;
        end else if (start_i) begin
            w_count_next  = r_reload;
            w_state_next  = ST_RUN;
        end else if (r_state == ST_RUN && en_i) begin
            if (w_at_term) begin
                if (mode_i)
                    w_state_next = ST_DONE;
                else
                    w_count_next = r_reload;
            end else if (dir_i) begin
                w_count_next = r_count - 1'b1;
            end else begin
                w_count_next = r_count + 1'b1;
            end
        end
    end

    assign count_o      = r_count;
    assign tc_o         = w_tc;
    assign running_o    = (r_state == ST_RUN);
    assign reload_val_o = r_reload;

`ifdef WRAP_CNT_EN
    logic [WRAP_W-1:0] r_wrap;

    // A load in the same cycle as a terminal event clears rather than counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_wrap <= '0;
        else if (load_i)
            r_wrap <= '0;
        else if (w_tc && (r_wrap != '1))
            r_wrap <= r_wrap + WRAP_W'(1);
    end

    assign wrap_cnt_o = r_wrap;
`endif

endmodule

// File: tb/tb_self_reload_counter_gen2.sv
// Randomised and directed bench for self_reload_counter_gen2 against a behavioural model.
module tb_self_reload_counter_gen2;

    localparam int W    = 4;
    localparam int MOD  = 1 << W;
    localparam int WW   = 2;
    localparam int WMAX = (1 << WW) - 1;

    logic         clk;
    logic         reset;
    logic         en_i, dir_i, mode_i, load_i, start_i;
    logic [W-1:0] load_val_i;
    logic [W-1:0] count_o, reload_val_o;
    logic         tc_o, running_o;
`ifdef WRAP_CNT_EN
    logic [WW-1:0] wrap_cnt_o;
`endif

    self_reload_counter_gen2 #(
        .WIDTH(W),
        .RESET_RELOAD(0),
        .WRAP_W(WW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en_i        (en_i),
        .dir_i       (dir_i),
        .mode_i      (mode_i),
        .load_i      (load_i),
        .load_val_i  (load_val_i),
        .start_i     (start_i),
        .count_o     (count_o),
        .tc_o        (tc_o),
        .running_o   (running_o),
        .reload_val_o(reload_val_o)
`ifdef WRAP_CNT_EN
        ,
        .wrap_cnt_o  (wrap_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Behavioural model: plain integers, modular arithmetic
    int m_count, m_reload, m_wrap;
    bit m_run;
    bit last_tc;
    int cyc;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_reload = 0; m_run = 1; m_wrap = 0;
    endtask

    function automatic int term_of(input bit dn);
        return dn ? 0 : MOD - 1;
    endfunction

    function automatic bit model_tc();
        return m_run && en_i && (m_count == term_of(dir_i));
    endfunction

    task automatic check_all(input string tag);
        check({tag, ":count"},  int'(count_o),      m_count);
        check({tag, ":tc"},     int'(tc_o),         int'(model_tc()));
        check({tag, ":run"},    int'(running_o),    int'(m_run));
        check({tag, ":reload"}, int'(reload_val_o), m_reload);
`ifdef WRAP_CNT_EN
        check({tag, ":wrap"},   int'(wrap_cnt_o),   m_wrap);
`endif
    endtask

    // Called at ~1ns after a rising edge with inputs already driven.
    task automatic cycle(input string tag);
        bit tc_pre;
        #4;
        check_all(tag);
        last_tc = tc_o;
        tc_pre  = model_tc();
        @(posedge clk);
        if (load_i) begin
            m_reload = int'(load_val_i); m_count = int'(load_val_i); m_run = 1;
            m_wrap   = 0;
        end else begin
            if (tc_pre && m_wrap < WMAX) m_wrap++;
            if (start_i) begin
                m_count = m_reload; m_run = 1;
            end else if (m_run && en_i) begin
                if (m_count == term_of(dir_i)) begin
                    if (mode_i) m_run = 0; else m_count = m_reload;
                end else begin
                    m_count = (m_count + (dir_i ? MOD - 1 : 1)) % MOD;
                end
            end
        end
        cyc++;
        #1;
        log_line(tag);
    endtask

    task automatic log_line(input string tag);
        $display("[%0t] %s count=%0d tc=%0b run=%0b reload=%0d", $time, tag,
                 count_o, last_tc, running_o, reload_val_o);
    endtask

    task automatic do_load(input int v);
        load_i = 1; load_val_i = W'(v);
        cycle("load");
        load_i = 0;
    endtask

    // Period from the spec formula, measured as distance between tc pulses.
    task automatic period_check(input int r, input bit dn);
        int first, second, expv;
        first = -1; second = -1;
        dir_i = dn; mode_i = 0; en_i = 1;
        do_load(r);
        for (int i = 0; i < 40 && second < 0; i++) begin
            cycle("period");
            if (last_tc) begin
                if (first < 0) first = i; else second = i;
            end
        end
        expv = dn ? r + 1 : MOD - r;
        check($sformatf("period r=%0d dn=%0b", r, dn), (second < 0) ? -1 : second - first, expv);
    endtask

    initial begin
        cyc = 0; last_tc = 0;
        reset = 0; en_i = 0; dir_i = 0; mode_i = 0; load_i = 0; start_i = 0; load_val_i = '0;
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk); #1;
        check_all("reset_hold");
        reset = 1;

        // 1: free-running up from 0
        en_i = 1;
        for (int i = 0; i < 18; i++) cycle("t1_up");
        // 2: load A, period 6
        do_load(10);
        for (int i = 0; i < 13; i++) cycle("t2_loadA");
        // 3: load 3 counting down, then freeze
        dir_i = 1;
        do_load(3);
        for (int i = 0; i < 9; i++) cycle("t3_down");
        en_i = 0;
        for (int i = 0; i < 5; i++) cycle("t3_freeze");
        en_i = 1;
        // 4: one-shot up from D, then restart
        dir_i = 0; mode_i = 1;
        do_load(13);
        for (int i = 0; i < 6; i++) cycle("t4_oneshot");
        check("t4_done_running", int'(running_o), 0);
        start_i = 1; cycle("t4_start"); start_i = 0;
        check("t4_restart_count", int'(count_o), 13);
        for (int i = 0; i < 3; i++) cycle("t4_after");
        // 5: load beats start
        mode_i = 0;
        do_load(9);
        load_i = 1; start_i = 1; load_val_i = 4'd2;
        cycle("t5_load_start");
        load_i = 0; start_i = 0;
        check("t5_count", int'(count_o), 2);
        // load coinciding with terminal in one-shot: no DONE entry
        mode_i = 1; do_load(14); cycle("t5_pre");
        load_i = 1; load_val_i = 4'd5; cycle("t5_load_at_tc"); load_i = 0;
        for (int i = 0; i < 2; i++) cycle("t5_post");
        mode_i = 0;
        // reload equals terminal: period 1
        do_load(15);
        for (int i = 0; i < 4; i++) cycle("t5_period1");

        // Periods from the arithmetic formulas
        for (int k = 0; k < 6; k++) period_check($urandom_range(0, MOD - 1), k[0]);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            en_i    = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 9) == 0) dir_i  = ~dir_i;
            if ($urandom_range(0, 9) == 0) mode_i = ~mode_i;
            load_i  = ($urandom_range(0, 19) == 0);
            start_i = ($urandom_range(0, 19) == 0);
            load_val_i = W'($urandom_range(0, MOD - 1));
            cycle("rand");
        end
        load_i = 0; start_i = 0;

        // Asynchronous reset between edges, mid-count
        dir_i = 0; mode_i = 0; en_i = 1;
        do_load(7);
        for (int i = 0; i < 3; i++) cycle("pre_rst");
        #2 reset = 0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk); #1;
        check_all("async_rst_hold");
        reset = 1;
        for (int i = 0; i < 4; i++) cycle("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
